// File: rtl/fp_div.sv
// Iterative single-precision divider: specials resolve in one cycle, everything
// else runs a 27-step restoring divide, then a normalize and a round stage.
module fp_div #(
  parameter int W = 32,
  parameter int M = 22,
  parameter int E = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  input  logic         act,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact,
  output logic         dz,
  output logic         busy,
  output logic         done
);

  localparam int FW = M + 1;
  localparam int EW = E - M;
  localparam int SW = FW + 1;
  localparam int QW = SW + 3;
  localparam int XW = EW + 2;
  localparam int CW = $clog2(QW);

  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 2);
  localparam logic signed [XW-1:0] EONE = XW'(1);

  // Rounding-mode codes shared with the other arithmetic blocks
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RNA = 3'd1;
  localparam logic [2:0] RM_RZ  = 3'd2;
  localparam logic [2:0] RM_RU  = 3'd3;
  localparam logic [2:0] RM_RD  = 3'd4;

  localparam logic [W-1:0] NAN_Q   = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  localparam logic [W-2:0] INF_MAG = {{EW{1'b1}}, {FW{1'b0}}};
  localparam logic [W-2:0] MAX_MAG = {{(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_ROUND} state_t;

  state_t r_state, w_next;

  logic              r_s;
  logic [EW-1:0]     r_ea, r_eb;
  logic [2:0]        r_rm;
  logic [SW-1:0]     r_mb;
  logic [SW:0]       r_rem;
  logic [QW-1:0]     r_q;
  logic [CW-1:0]     r_cnt;
  logic [FW-1:0]     r_mant;
  logic              r_g, r_st;
  logic signed [XW-1:0] r_exp;

  logic          w_s1, w_s2, w_sign;
  logic [EW-1:0] w_e1, w_e2;
  logic [FW-1:0] w_f1, w_f2;
  logic w_z1, w_z2, w_i1, w_i2, w_n1, w_n2, w_sn1, w_sn2;

  assign w_s1   = in1[W-1];
  assign w_s2   = in2[W-1];
  assign w_e1   = in1[E:M+1];
  assign w_e2   = in2[E:M+1];
  assign w_f1   = in1[M:0];
  assign w_f2   = in2[M:0];
  assign w_sign = w_s1 ^ w_s2;
  // Exponent 0 means zero regardless of fraction: denormals are flushed
  assign w_z1   = (w_e1 == '0);
  assign w_z2   = (w_e2 == '0);
  assign w_i1   = (&w_e1) && (w_f1 == '0);
  assign w_i2   = (&w_e2) && (w_f2 == '0);
  assign w_n1   = (&w_e1) && (w_f1 != '0);
  assign w_n2   = (&w_e2) && (w_f2 != '0);
  assign w_sn1  = w_n1 && !w_f1[FW-1];
  assign w_sn2  = w_n2 && !w_f2[FW-1];

  logic          w_special, w_sp_inv, w_sp_dz;
  logic [W-1:0]  w_sp_out;

  always_comb begin
    w_special = 1'b1;
    w_sp_out  = '0;
    w_sp_inv  = 1'b0;
    w_sp_dz   = 1'b0;
    if (w_n1 || w_n2) begin
      w_sp_out = NAN_Q;
      w_sp_inv = w_sn1 || w_sn2;
    end else if ((w_z1 && w_z2) || (w_i1 && w_i2)) begin
      w_sp_out = NAN_Q;
      w_sp_inv = 1'b1;
    end else if (w_z2 && !w_i1) begin
      w_sp_out = {w_sign, INF_MAG};
      w_sp_dz  = 1'b1;
    end else if (w_i1) begin
      w_sp_out = {w_sign, INF_MAG};
    end else if (w_z1 || w_i2) begin
      w_sp_out = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  logic          w_ge, w_last;
  logic [SW:0]   w_diff;

  assign w_ge   = (r_rem >= {1'b0, r_mb});
  assign w_diff = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_last = (r_cnt == CW'(QW - 1));

  logic signed [XW-1:0] w_ediff, w_n_exp;
  logic [FW-1:0]        w_n_mant;
  logic                 w_n_g, w_n_st, w_rem_nz;

  assign w_ediff  = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb});
  assign w_rem_nz = (r_rem != '0);

  always_comb begin
    if (r_q[QW-1]) begin
      w_n_mant = r_q[QW-2:3];
      w_n_g    = r_q[2];
      w_n_st   = r_q[1] | r_q[0] | w_rem_nz;
      w_n_exp  = w_ediff + BIAS;
    end else begin
      w_n_mant = r_q[QW-3:2];
      w_n_g    = r_q[1];
      w_n_st   = r_q[0] | w_rem_nz;
      w_n_exp  = w_ediff + BIAS - EONE;
    end
  end

  logic                 w_inc, w_r_ov, w_r_un, w_r_inx;
  logic [FW:0]          w_mant_r;
  logic signed [XW-1:0] w_exp_r;
  logic [W-1:0]         w_r_out;

  always_comb begin
    case (r_rm)
      RM_RNA:  w_inc = r_g;
      RM_RZ:   w_inc = 1'b0;
      RM_RU:   w_inc = (r_g | r_st) & ~r_s;
      RM_RD:   w_inc = (r_g | r_st) & r_s;
      default: w_inc = r_g & (r_st | r_mant[0]);
    endcase
    // Carry-out leaves the low FW bits at zero, i.e. 1.0 at the next exponent
    w_mant_r = {1'b0, r_mant} + {{FW{1'b0}}, w_inc};
    w_exp_r  = r_exp + {{(XW-1){1'b0}}, w_mant_r[FW]};
    w_r_ov   = 1'b0;
    w_r_un   = 1'b0;
    w_r_inx  = r_g | r_st;
    w_r_out  = {r_s, w_exp_r[EW-1:0], w_mant_r[FW-1:0]};
    if (w_exp_r > EMAX) begin
      w_r_ov  = 1'b1;
      w_r_inx = 1'b1;
      case (r_rm)
        RM_RZ:   w_r_out = {r_s, MAX_MAG};
        RM_RU:   w_r_out = r_s ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
        RM_RD:   w_r_out = r_s ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
        default: w_r_out = {r_s, INF_MAG};
      endcase
    end else if (w_exp_r < EONE) begin
      w_r_un  = 1'b1;
      w_r_inx = 1'b1;
      w_r_out = {r_s, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (act && !w_special) w_next = S_DIV;
      S_DIV:   if (w_last) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= '0;
      ov      <= 1'b0;
      un      <= 1'b0;
      inv     <= 1'b0;
      inexact <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_s     <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_rm    <= '0;
      r_mb    <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mant  <= '0;
      r_g     <= 1'b0;
      r_st    <= 1'b0;
      r_exp   <= '0;
    end else begin
      done <= 1'b0;
      busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (act) begin
            if (w_special) begin
              out     <= w_sp_out;
              inv     <= w_sp_inv;
              dz      <= w_sp_dz;
              ov      <= 1'b0;
              un      <= 1'b0;
              inexact <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_s   <= w_sign;
              r_ea  <= w_e1;
              r_eb  <= w_e2;
              r_rm  <= round_m;
              r_mb  <= {1'b1, w_f2};
              r_rem <= {2'b01, w_f1};
              r_q   <= '0;
              r_cnt <= '0;
            end
          end
        end
        S_DIV: begin
          r_q   <= {r_q[QW-2:0], w_ge};
          // Last step keeps the true remainder; earlier steps pre-shift it
          r_rem <= w_last ? w_diff : {w_diff[SW-1:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
        end
        S_NORM: begin
          r_mant <= w_n_mant;
          r_g    <= w_n_g;
          r_st   <= w_n_st;
          r_exp  <= w_n_exp;
        end
        S_ROUND: begin
          out     <= w_r_out;
          ov      <= w_r_ov;
          un      <= w_r_un;
          inexact <= w_r_inx;
          inv     <= 1'b0;
          dz      <= 1'b0;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: expectations queued at issue time, popped and
// checked when done arrives; latency counted in edges after the accepting edge.
module tb_fp_div;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RNA = 3'd1;
  localparam logic [2:0] RZ  = 3'd2;
  localparam logic [2:0] RU  = 3'd3;
  localparam logic [2:0] RD  = 3'd4;

  // Flag vector order: {ov, un, inv, inexact, dz}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_OV   = 5'b10000;
  localparam logic [4:0] F_UN   = 5'b01000;
  localparam logic [4:0] F_INV  = 5'b00100;
  localparam logic [4:0] F_INX  = 5'b00010;
  localparam logic [4:0] F_DZ   = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1, in2;
  logic [2:0]  round_m;
  logic        act;
  logic [31:0] out;
  logic        ov, un, inv, inexact, dz, busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic [4:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fp_div dut (
    .clk     (clk),
    .rst     (rst),
    .in1     (in1),
    .in2     (in2),
    .round_m (round_m),
    .act     (act),
    .out     (out),
    .ov      (ov),
    .un      (un),
    .inv     (inv),
    .inexact (inexact),
    .dz      (dz),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    in1     = a;
    in2     = b;
    round_m = rm;
    act     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    act     = 1'b0;
    cyc     = 0;
    in1     = $urandom;
    in2     = $urandom;
    round_m = 3'($urandom_range(0, 4));
  endtask

  task automatic start(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [31:0] eo, input logic [4:0] ef,
                       input int lat);
    exp_t e;
    e.tag   = tag;
    e.out   = eo;
    e.flags = ef;
    e.lat   = lat;
    sb.push_back(e);
    drive(a, b, rm);
  endtask

  task automatic collect();
    exp_t e;
    bit   seen;
    e    = sb.pop_front();
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (done === 1'b1) seen = 1'b1;
      else step();
    end
    n_assert++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed no done in %0d cycles expected done at %0d", e.tag, cyc, e.lat);
    end
    if (seen) begin
      check({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({e.tag, "_out"}, out, e.out);
      check({e.tag, "_flags"}, {27'd0, ov, un, inv, inexact, dz}, {27'd0, e.flags});
      $display("op %s: out=%h flags=%b latency=%0d", e.tag, out, {ov, un, inv, inexact, dz}, cyc);
      step();
      check({e.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic quiet_window(input string tag);
    int n;
    n = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  initial begin
    rst = 1'b0; act = 1'b0; in1 = '0; in2 = '0; round_m = RNE;
    repeat (2) @(negedge clk);
    check("reset_out", out, 32'd0);
    check("reset_status", {25'd0, ov, un, inv, inexact, dz, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    start("div6by2_rne",   32'h40C00000, 32'h40000000, RNE, 32'h40400000, F_NONE, 29); collect();
    start("third_rne",     32'h3F800000, 32'h40400000, RNE, 32'h3EAAAAAB, F_INX, 29);  collect();
    start("third_rz",      32'h3F800000, 32'h40400000, RZ,  32'h3EAAAAAA, F_INX, 29);  collect();
    start("negthird_rd",   32'hBF800000, 32'h40400000, RD,  32'hBEAAAAAB, F_INX, 29);  collect();
    start("negthird_ru",   32'hBF800000, 32'h40400000, RU,  32'hBEAAAAAA, F_INX, 29);  collect();
    start("one_rna",       32'h3F800000, 32'h3F800000, RNA, 32'h3F800000, F_NONE, 29); collect();
    start("div_by_zero",   32'h3F800000, 32'h00000000, RNE, 32'h7F800000, F_DZ, 0);    collect();
    start("zero_by_zero",  32'h00000000, 32'h00000000, RNE, 32'h7FC00000, F_INV, 0);   collect();
    start("ovf_rne",       32'h7F000000, 32'h3E800000, RNE, 32'h7F800000, F_OV | F_INX, 29); collect();
    start("ovf_rz",        32'h7F000000, 32'h3E800000, RZ,  32'h7F7FFFFF, F_OV | F_INX, 29); collect();
    start("negovf_ru",     32'hFF000000, 32'h3E800000, RU,  32'hFF7FFFFF, F_OV | F_INX, 29); collect();
    start("underflow",     32'h00800000, 32'h7F000000, RNE, 32'h00000000, F_UN | F_INX, 29); collect();
    start("snan_operand",  32'h7F800001, 32'h3F800000, RNE, 32'h7FC00000, F_INV, 0);   collect();
    start("inf_by_two",    32'h7F800000, 32'h40000000, RNE, 32'h7F800000, F_NONE, 0);  collect();
    start("neg_by_inf",    32'hC0000000, 32'h7F800000, RNE, 32'h80000000, F_NONE, 0);  collect();
    start("denorm_flush",  32'h00000001, 32'h3F800000, RNE, 32'h00000000, F_NONE, 0);  collect();
    start("inf_by_inf",    32'h7F800000, 32'h7F800000, RNE, 32'h7FC00000, F_INV, 0);   collect();

    // A second act during DIV must be ignored entirely
    start("ignored_act",   32'h40C00000, 32'h40000000, RNE, 32'h40400000, F_NONE, 29);
    repeat (5) step();
    check("busy_in_div", {31'd0, busy}, 32'd1);
    in1 = 32'h3F800000; in2 = 32'h40400000; round_m = RZ; act = 1'b1;
    step();
    act = 1'b0;
    collect();
    quiet_window("no_second_done");

    // Reset in the middle of an operation aborts it
    drive(32'h3F800000, 32'h40400000, RNE);
    repeat (9) step();
    rst = 1'b0;
    #1;
    check("midop_reset_out", out, 32'd0);
    check("midop_reset_status", {25'd0, ov, un, inv, inexact, dz, busy, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    quiet_window("no_done_after_abort");

    start("neg6by2_after_rst", 32'hC0C00000, 32'h40000000, RNE, 32'hC0400000, F_NONE, 29); collect();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 Parameter W, default 32, total word width.
REQ-002 Parameter M, default 22, MSB index of the stored mantissa field.
REQ-003 Parameter E, default 30, MSB index of the exponent field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in1  input  W  dividend, IEEE-754 single, sampled when the operation is accepted.
REQ-007 in2  input  W  divisor, IEEE-754 single, sampled when the operation is accepted.
REQ-008 round_m  input  3  rounding mode, decoded with the `RNe/`RNa/`RZ/`RU/`RD macros of special_characters.v, sampled with in1/in2.
REQ-009 act  input  1  start request.
REQ-010 out  output  W  registered quotient.
REQ-011 ov, un, inv, inexact  output  1 each  registered exception flags; same meanings as the fp_add flags.
REQ-012 dz  output  1  registered divide-by-zero flag.
REQ-013 busy  output  1  high while an operation is in flight.
REQ-014 done  output  1  one-cycle pulse, high when out and the flags are valid.

Function
REQ-015 FSM states: IDLE, DIV, NORM, ROUND.
- Transitions: IDLE -> DIV on act with a non-special operand pair; DIV -> NORM after 27 iterations; NORM -> ROUND; ROUND -> IDLE.
REQ-016 act is accepted only in IDLE; act in any other state is ignored and the in-flight operation continues unchanged.
REQ-017 Operands are captured at acceptance; in1, in2 and round_m may change afterwards without effect.
REQ-018 Sign of every result = S1^S2, except for NaN results.
REQ-019 Operands with exponent 0 are treated as signed zero (denormal flush).
REQ-020 Special operand pairs are resolved in IDLE; done pulses on the next edge, 1-cycle latency, never entering DIV.
- Either operand NaN -> `FP_NANQ; inv=1 if either operand is `FP_NANS.
- 0/0 or inf/inf -> `FP_NANQ, inv=1.
- Finite nonzero / 0 -> signed infinity, dz=1.
- inf / finite -> signed infinity.
- 0 / nonzero, or finite / inf -> signed zero.
REQ-021 DIV: restoring division on the 24-bit significands {1,frac}, one quotient bit per cycle, 27 cycles.
- Produces q = floor((ma<<26)/mb); q lies in [2^25, 2^27).
- The final remainder is retained.
REQ-022 NORM, case q[26]=1: mantissa q[25:3], guard q[2], sticky = q[1]|q[0]|(rem!=0), biased exponent = E1-E2+127.
REQ-023 NORM, case q[26]=0: mantissa q[24:2], guard q[1], sticky = q[0]|(rem!=0), biased exponent = E1-E2+126.
- The exponent is computed at 10-bit signed width.
REQ-024 ROUND applies the fp_add rules: RNe ties-to-even, RNa ties-away, RZ truncate, RU toward +inf, RD toward -inf.
- A mantissa carry-out increments the exponent.
REQ-025 inexact = guard|sticky for every non-special result.
REQ-026 Overflow, rounded exponent > 254: ov=1, inexact=1; the result depends on mode.
- RNe/RNa: signed infinity.
- RZ: signed 0x7F7FFFFF magnitude.
- RU: +inf if positive, else -max finite.
- RD: -inf if negative, else +max finite.
REQ-027 Underflow, rounded exponent < 1: out = signed zero, un=1, inexact=1.
REQ-028 Normal-path latency is 29 cycles.
- act is sampled at edge 0; done is high in the cycle after edge 29.
- busy is high from edge 1 through the done cycle.
REQ-029 out and the flags are updated only together with done; between operations they hold their last values.
REQ-030 All flags not set by the current operation are written 0 at done.

Reset
REQ-031 On rst low, immediately: FSM=IDLE, out=0, ov=un=inv=inexact=dz=0, busy=0, done=0, iteration counter=0, quotient/remainder=0.
REQ-032 Reset asserted mid-operation aborts the operation; no done pulse follows.
- The first act after rst deasserts starts a fresh operation.

Verification
REQ-033 0x40C00000 / 0x40000000, RNe -> out=0x40400000, inexact=0, done 29 cycles after act.
REQ-034 0x3F800000 / 0x40400000 -> RNe: 0x3EAAAAAB; RZ: 0x3EAAAAAA; inexact=1 in both modes.
REQ-035 0x3F800000 / 0x00000000 -> out=0x7F800000, dz=1, done 1 cycle after act; 0x00000000 / 0x00000000 -> `FP_NANQ, inv=1.
REQ-036 0x7F000000 / 0x3E800000 -> RNe: 0x7F800000, ov=1, inexact=1; RZ: 0x7F7FFFFF, ov=1.
REQ-037 Directed sequence, all responses required:
- act pulsed again during DIV -> ignored, no change to the result.
- rst pulsed low at cycle 10 -> all outputs 0, no done.
- Then 0xC0C00000 / 0x40000000 -> out=0xC0400000 after 29 cycles.
